// File: rtl/conway_uart_pkg.sv
// Shared types and constants for the Conway-display UART path.
// Holds the arbiter state type, ASCII codes and default sizing.
package conway_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_SEND = 2'd2
    } arb_state_t;

    localparam logic [7:0] ESC      = 8'd27;
    localparam logic [7:0] CR       = 8'd13;
    localparam logic [7:0] LF       = 8'd10;
    localparam logic [7:0] CELL_ON  = 8'd79;
    localparam logic [7:0] CELL_OFF = 8'd32;

    localparam int NREQ_DEF    = 3;
    localparam int TIMEOUT_DEF = 4096;

    // Index width that stays legal when only one requester exists.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin pick: first set request at or after i_ptr, wrapping.
// Purely combinational; returns one-hot winner and its index.
module rr_priority_select #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0] w_pos;
    logic        w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        w_pos    = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_pos >= (IW+1)'(N)) begin
                w_pos = w_pos - (IW+1)'(N);
            end
            if (!w_found && i_req[w_pos[IW-1:0]]) begin
                w_found                  = 1'b1;
                o_idx                    = w_pos[IW-1:0];
                o_onehot[w_pos[IW-1:0]]  = 1'b1;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-locked round-robin arbiter feeding byte streams into one UART
// transmitter, with an idle timeout that frees a stalled frame.
module uart_tx_arbiter
    import conway_uart_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk48,
    input  logic              boot_reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              timeout
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_t      r_state, w_state_n;
    logic [NREQ-1:0] r_grant, w_grant_n;
    logic [NREQ-1:0] r_req_ready, w_req_ready_n;
    logic [IW-1:0]   r_gidx, w_gidx_n;
    logic [IW-1:0]   r_ptr, w_ptr_n;
    logic [7:0]      r_tx_data, w_tx_data_n;
    logic            r_tx_valid, w_tx_valid_n;
    logic            r_last, w_last_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic            r_timeout, w_timeout_n;

    logic [NREQ-1:0] w_win;
    logic [IW-1:0]   w_win_idx;
    logic            w_any;
    logic [IW-1:0]   w_gnext;
    logic            w_own_valid;
    logic            w_own_last;
    logic [7:0]      w_own_data;

    rr_priority_select #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_win),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    // Owner's lane, selected by the locked grant index.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gidx == IW'(i)) begin
                w_own_valid = req_valid[i];
                w_own_last  = req_last[i];
                w_own_data  = req_data[8*i +: 8];
            end
        end
    end

    assign w_gnext = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + 1'b1;

    always_comb begin
        w_state_n     = r_state;
        w_grant_n     = r_grant;
        w_gidx_n      = r_gidx;
        w_ptr_n       = r_ptr;
        w_tx_data_n   = r_tx_data;
        w_tx_valid_n  = r_tx_valid;
        w_req_ready_n = '0;
        w_last_n      = r_last;
        w_cnt_n       = r_cnt;
        w_timeout_n   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_grant_n = w_win;
                    w_gidx_n  = w_win_idx;
                    w_cnt_n   = '0;
                    w_state_n = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_own_valid) begin
                    // Stalls on tx_ready do not count toward the timeout.
                    if (tx_ready) begin
                        w_tx_data_n   = w_own_data;
                        w_tx_valid_n  = 1'b1;
                        w_req_ready_n = r_grant;
                        w_last_n      = w_own_last;
                        w_cnt_n       = '0;
                        w_state_n     = ST_SEND;
                    end
                end else if (r_cnt == CW'(TIMEOUT - 1)) begin
                    w_timeout_n = 1'b1;
                    w_grant_n   = '0;
                    w_ptr_n     = w_gnext;
                    w_cnt_n     = '0;
                    w_state_n   = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            ST_SEND: begin
                if (!tx_ready) begin
                    w_tx_valid_n = 1'b0;
                    if (r_last) begin
                        w_grant_n = '0;
                        w_ptr_n   = w_gnext;
                        w_state_n = ST_IDLE;
                    end else begin
                        w_state_n = ST_ARM;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk48) begin
        if (boot_reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_gidx      <= '0;
            r_ptr       <= '0;
            r_tx_data   <= 8'h00;
            r_tx_valid  <= 1'b0;
            r_req_ready <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_grant     <= w_grant_n;
            r_gidx      <= w_gidx_n;
            r_ptr       <= w_ptr_n;
            r_tx_data   <= w_tx_data_n;
            r_tx_valid  <= w_tx_valid_n;
            r_req_ready <= w_req_ready_n;
            r_last      <= w_last_n;
            r_cnt       <= w_cnt_n;
            r_timeout   <= w_timeout_n;
        end
    end

    assign req_ready = r_req_ready;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign grant     = r_grant;
    assign busy      = |r_grant;
    assign timeout   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-driven requesters, a transmitter
// model, and a per-cycle behavioural reference.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         boot_reset;
    logic [N-1:0] req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0] req_last;
    logic [N-1:0] req_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [N-1:0] grant;
    logic         busy;
    logic         timeout;

    uart_tx_arbiter #(
        .NREQ    (N),
        .TIMEOUT (TO)
    ) dut (
        .clk48      (clk),
        .boot_reset (boot_reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .grant      (grant),
        .busy       (busy),
        .timeout    (timeout)
    );

    initial forever #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Requester byte queues: {last, byte}
    logic [8:0] rq [N][$];
    bit         rnd_gaps = 0;
    bit         bp_force = 0;

    // Transmitter model state
    bit         pv = 0;
    bit         pr = 1;
    int         xm_left = 0;

    initial begin : drive
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_ready  = 1'b1;
        forever begin
            @(negedge clk);
            // transmitter: takes a byte on valid&ready at the edge,
            // goes low one cycle after tx_valid, back 10 cycles later
            if (xm_left > 0) xm_left--;
            if (pv && pr) xm_left = 10;
            tx_ready = (xm_left == 0) && !bp_force;
            pv = tx_valid;
            pr = tx_ready;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0 &&
                    !(rnd_gaps && $urandom_range(0, 9) == 0)) begin
                    req_valid[i]       = 1'b1;
                    req_data[8*i +: 8] = rq[i][0][7:0];
                    req_last[i]        = rq[i][0][8];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    // Behavioural reference: owner/ptr as integers, outputs per edge.
    int         m_owner = -1;
    int         m_nxt = 0;
    bit         m_inflight = 0;
    bit         m_endframe = 0;
    int         m_idle = 0;
    bit         m_live = 0;
    logic [N-1:0] e_grant = '0;
    logic [N-1:0] e_rdy = '0;
    logic       e_txv = 0;
    logic [7:0] e_txd = '0;
    logic       e_to = 0;

    always @(posedge clk) begin
        if (boot_reset) begin
            m_owner = -1; m_nxt = 0; m_inflight = 0;
            m_endframe = 0; m_idle = 0;
            e_grant = '0; e_rdy = '0; e_txv = 0; e_txd = '0; e_to = 0;
        end else begin
            e_rdy = '0;
            e_to  = 0;
            if (m_owner < 0) begin
                for (int k = 0; k < N; k++)
                    if (m_owner < 0 && req_valid[(m_nxt + k) % N])
                        m_owner = (m_nxt + k) % N;
                m_idle = 0;
            end else if (m_inflight) begin
                if (!tx_ready) begin
                    e_txv = 0;
                    m_inflight = 0;
                    if (m_endframe) begin
                        m_nxt = (m_owner + 1) % N;
                        m_owner = -1;
                    end
                end
            end else if (req_valid[m_owner]) begin
                if (tx_ready) begin
                    e_txd = req_data[8*m_owner +: 8];
                    e_txv = 1;
                    e_rdy[m_owner] = 1'b1;
                    m_endframe = req_last[m_owner];
                    m_idle = 0;
                    m_inflight = 1;
                end
            end else begin
                m_idle++;
                if (m_idle == TO) begin
                    e_to = 1;
                    m_nxt = (m_owner + 1) % N;
                    m_owner = -1;
                    m_idle = 0;
                end
            end
            e_grant = '0;
            if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        end
        m_live = 1;
    end

    // Observation logs
    int a_idx[$];
    int a_byte[$];
    int glog[$];
    logic [N-1:0] prev_g = '0;
    int to_cnt = 0;
    int to_cyc = 0;
    int rdy_cyc = 0;
    int txv_cnt = 0;

    initial begin : compare
        forever begin
            @(negedge clk);
            cyc++;
            if (m_live) begin
                check("grant", grant, e_grant);
                check("busy", busy, e_grant != '0);
                check("req_ready", req_ready, e_rdy);
                check("tx_valid", tx_valid, e_txv);
                check("tx_data", tx_data, e_txd);
                check("timeout", timeout, e_to);
            end
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    a_idx.push_back(i);
                    a_byte.push_back(int'(tx_data));
                    rdy_cyc = cyc;
                end
                if (grant[i] && grant != prev_g) glog.push_back(i);
            end
            prev_g = grant;
            if (timeout) begin
                to_cnt++;
                to_cyc = cyc;
            end
            if (tx_valid) txv_cnt++;
        end
    end

    function automatic int qget(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    function automatic bit q_empty();
        bit e = 1;
        for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 0;
        return e;
    endfunction

    task automatic push(input int r, input logic [7:0] b, input bit l);
        rq[r].push_back({l, b});
    endtask

    task automatic clear_logs();
        a_idx.delete();
        a_byte.delete();
        glog.delete();
    endtask

    task automatic wait_quiet(input string nm, input int budget);
        bit ok = 0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (q_empty() && grant == '0 && !tx_valid && tx_ready) ok = 1;
        end
        check(nm, ok, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        boot_reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        repeat (2) @(negedge clk);
        boot_reset = 1'b0;
    endtask

    int sf[3] = '{8'h1B, 8'h5B, 8'h48};
    int order[6] = '{0, 1, 2, 0, 1, 2};
    int lk[4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0] pq [N][$];

    initial begin : main
        int g0, t0, v0, mism, pushed, r, len, ones, eb;
        bit ok;
        logic [7:0] v;

        boot_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_timeout", timeout, 0);
        check("rst_req_ready", req_ready, 0);
        boot_reset = 1'b0;

        // single frame from requester 1
        @(negedge clk);
        clear_logs();
        push(1, 8'h1B, 0);
        push(1, 8'h5B, 0);
        push(1, 8'h48, 1);
        wait_quiet("single_drain", 200);
        check("single_count", a_idx.size(), 3);
        ones = 0;
        for (int k = 0; k < a_idx.size(); k++) if (a_idx[k] == 1) ones++;
        check("single_rdy1_pulses", ones, 3);
        for (int k = 0; k < 3; k++)
            check("single_byte", qget(a_byte, k), sf[k]);
        check("single_grant_end", grant, 0);

        // contention after reset: two rounds of 1-byte frames
        do_reset();
        clear_logs();
        for (int rd = 0; rd < 2; rd++) begin
            push(0, 8'h30, 1);
            push(1, 8'h31, 1);
            push(2, 8'h32, 1);
            wait_quiet("cont_drain", 300);
        end
        for (int k = 0; k < 6; k++)
            check("cont_order", qget(glog, k), order[k]);

        // frame lock: req 0 four bytes, req 2 waiting
        clear_logs();
        for (int k = 0; k < 4; k++) push(0, 8'(lk[k]), k == 3);
        push(2, 8'hC0, 1);
        wait_quiet("lock_drain", 400);
        check("lock_count", a_idx.size(), 5);
        for (int k = 0; k < 4; k++) begin
            check("lock_owner", qget(a_idx, k), 0);
            check("lock_byte", qget(a_byte, k), lk[k]);
        end
        check("lock_req2_after", qget(a_idx, 4), 2);
        check("lock_next_grant", qget(glog, 1), 2);

        // timeout: req 1 sends a non-last byte then goes silent
        clear_logs();
        t0 = to_cnt;
        push(1, 8'h55, 0);
        wait_quiet("to_release", 200);
        check("to_pulses", to_cnt - t0, 1);
        // 2 SEND cycles then 16 idle ARM cycles after the req_ready pulse
        check("to_latency", to_cyc - rdy_cyc, 18);
        check("to_grant", grant, 0);
        check("to_model_ptr", m_nxt, 2);
        g0 = glog.size();
        push(0, 8'h60, 1);
        push(2, 8'h62, 1);
        wait_quiet("to_after_drain", 300);
        check("to_next_winner", qget(glog, g0), 2);

        // backpressure: tx_ready held low while a byte waits in ARM
        bp_force = 1;
        repeat (2) @(negedge clk);
        t0 = to_cnt;
        v0 = txv_cnt;
        push(0, 8'h4F, 1);
        repeat (100) @(negedge clk);
        check("bp_no_timeout", to_cnt - t0, 0);
        check("bp_no_txvalid", txv_cnt - v0, 0);
        check("bp_grant", grant, 3'b001);
        bp_force = 0;
        wait_quiet("bp_drain", 200);
        check("bp_byte", qget(a_byte, a_byte.size() - 1), 8'h4F);
        check("bp_owner", qget(a_idx, a_idx.size() - 1), 0);

        // reset while a byte is in SEND; ptr was 1 beforehand
        push(1, 8'h77, 0);
        push(1, 8'h78, 1);
        ok = 0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (tx_valid) ok = 1;
        end
        check("rs_reach_send", ok, 1);
        boot_reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        @(negedge clk);
        boot_reset = 1'b0;
        check("rs_tx_valid", tx_valid, 0);
        check("rs_grant", grant, 0);
        check("rs_busy", busy, 0);
        wait_quiet("rs_settle", 100);
        g0 = glog.size();
        push(1, 8'h81, 1);
        push(0, 8'h80, 1);
        wait_quiet("rs_drain", 300);
        check("rs_first_winner", qget(glog, g0), 0);

        // randomized frames with occasional valid gaps
        clear_logs();
        for (int i = 0; i < N; i++) pq[i].delete();
        pushed = 0;
        rnd_gaps = 1;
        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                v = 8'($urandom);
                push(r, v, b == len - 1);
                pq[r].push_back(v);
                pushed++;
            end
            repeat ($urandom_range(0, 25)) @(negedge clk);
        end
        rnd_gaps = 0;
        wait_quiet("rnd_drain", 30000);
        check("rnd_count", a_idx.size(), pushed);
        mism = 0;
        for (int k = 0; k < a_idx.size(); k++) begin
            if (pq[a_idx[k]].size() == 0) begin
                mism++;
            end else begin
                eb = int'(pq[a_idx[k]].pop_front());
                if (eb != a_byte[k]) mism++;
            end
        end
        check("rnd_stream", mism, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish, required finish by 90000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
